// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: machine-level interrupt source feeding the CSR file.
// Holds a memory-mapped 64-bit mtime/mtimecmp timer with prescaler and a
// synchronised, edge-detected external interrupt line. Presents a 4-bit
// interrupt code (0 none, 1 timer, 2 external) held until irq_ack.
//
// Ports:
//   clk        core clock
//   rst        asynchronous active-high reset
//   bus_sel    register access strobe
//   bus_wr     1 = write, 0 = read (qualified by bus_sel)
//   bus_addr   word index: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO,
//              3 MTIMECMP_HI, 4 CTRL, 5 STATUS (W1C), 6/7 reserved
//   bus_wdata  write data
//   bus_rdata  combinational read data, 0 when not reading
//   ext_irq_i  asynchronous external interrupt line
//   irq_ack    one-cycle pulse: core took the presented interrupt
//   interrupt  code to the CSR file
module irq_timer_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESCALE_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_wr,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq_i,
  input  logic        irq_ack,
  output logic [3:0]  interrupt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_TMR = 2'd1,
    REQ_EXT = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [63:0]             mtime;
  logic [63:0]             mtimecmp;
  logic                    timer_en;
  logic                    ext_en;
  logic [PRESCALE_W-1:0]   prescale;
  logic [PRESCALE_W-1:0]   ps_cnt;
  logic                    timer_pend, timer_pend_n;
  logic                    ext_pend, ext_pend_n;
  logic                    cmp, cmp_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ext_prev;

  logic wr;
  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
  logic ps_hit;
  logic timer_set, ext_set;
  logic timer_clr, ext_clr;

  always_comb begin
    wr          = bus_sel && bus_wr;
    wr_mtime_lo = wr && (bus_addr == 3'd0);
    wr_mtime_hi = wr && (bus_addr == 3'd1);
    wr_cmp_lo   = wr && (bus_addr == 3'd2);
    wr_cmp_hi   = wr && (bus_addr == 3'd3);
    wr_ctrl     = wr && (bus_addr == 3'd4);
    wr_status   = wr && (bus_addr == 3'd5);

    ps_hit    = timer_en && (ps_cnt == prescale);
    cmp       = timer_en && (mtime >= mtimecmp);
    timer_set = cmp && !cmp_q;
    ext_set   = ext_en && sync_q[SYNC_STAGES-1] && !ext_prev;

    timer_clr = (wr_status && bus_wdata[0]) || ((state == REQ_TMR) && irq_ack);
    ext_clr   = (wr_status && bus_wdata[1]) || ((state == REQ_EXT) && irq_ack);

    // Disabling a source kills its pend bit outright; otherwise a new
    // edge beats a same-cycle W1C or ack so it is never lost.
    if (wr_ctrl && !bus_wdata[0])
      timer_pend_n = 1'b0;
    else if (timer_set)
      timer_pend_n = 1'b1;
    else if (timer_clr)
      timer_pend_n = 1'b0;
    else
      timer_pend_n = timer_pend;

    if (wr_ctrl && !bus_wdata[1])
      ext_pend_n = 1'b0;
    else if (ext_set)
      ext_pend_n = 1'b1;
    else if (ext_clr)
      ext_pend_n = 1'b0;
    else
      ext_pend_n = ext_pend;
  end

  // Withdraw decisions look at the next pend value so a software clear
  // drops the code on the same edge that clears the bit.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ext_pend && ext_pend_n)
          state_n = REQ_EXT;
        else if (timer_pend && timer_pend_n)
          state_n = REQ_TMR;
      end
      REQ_TMR: begin
        if (irq_ack || !timer_pend_n)
          state_n = IDLE;
      end
      REQ_EXT: begin
        if (irq_ack || !ext_pend_n)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      REQ_TMR: interrupt = 4'd1;
      REQ_EXT: interrupt = 4'd2;
      default: interrupt = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mtime      <= '0;
      mtimecmp   <= '1;
      timer_en   <= 1'b0;
      ext_en     <= 1'b0;
      prescale   <= '0;
      ps_cnt     <= '0;
      timer_pend <= 1'b0;
      ext_pend   <= 1'b0;
      cmp_q      <= 1'b0;
      sync_q     <= '0;
      ext_prev   <= 1'b0;
    end else begin
      state      <= state_n;
      timer_pend <= timer_pend_n;
      ext_pend   <= ext_pend_n;
      cmp_q      <= cmp;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
      ext_prev   <= sync_q[SYNC_STAGES-1];

      if (wr_mtime_lo)
        mtime[31:0] <= bus_wdata;
      else if (wr_mtime_hi)
        mtime[63:32] <= bus_wdata;
      else if (ps_hit)
        mtime <= mtime + 64'd1;

      if (wr_cmp_lo)
        mtimecmp[31:0] <= bus_wdata;
      if (wr_cmp_hi)
        mtimecmp[63:32] <= bus_wdata;

      if (wr_ctrl) begin
        timer_en <= bus_wdata[0];
        ext_en   <= bus_wdata[1];
        prescale <= bus_wdata[8 +: PRESCALE_W];
        ps_cnt   <= '0;
      end else if (timer_en) begin
        ps_cnt <= ps_hit ? '0 : ps_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_sel && !bus_wr) begin
      case (bus_addr)
        3'd0: bus_rdata = mtime[31:0];
        3'd1: bus_rdata = mtime[63:32];
        3'd2: bus_rdata = mtimecmp[31:0];
        3'd3: bus_rdata = mtimecmp[63:32];
        3'd4: begin
          bus_rdata[0]              = timer_en;
          bus_rdata[1]              = ext_en;
          bus_rdata[8 +: PRESCALE_W] = prescale;
        end
        3'd5: begin
          bus_rdata[0] = timer_pend;
          bus_rdata[1] = ext_pend;
        end
        default: bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
module tb_irq_timer_ctrl;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel;
  logic        bus_wr;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        ext_irq_i;
  logic        irq_ack;
  logic [3:0]  interrupt;

  int passed = 0;
  int total  = 0;

  irq_timer_ctrl #(
    .SYNC_STAGES(SYNC),
    .PRESCALE_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_sel(bus_sel),
    .bus_wr(bus_wr),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .ext_irq_i(ext_irq_i),
    .irq_ack(irq_ack),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the next negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_sel   = 1'b1;
    bus_wr    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0;
    bus_wr  = 1'b0;
  endtask

  // Combinational read, consumes no clock edge.
  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_sel  = 1'b1;
    bus_wr   = 1'b0;
    bus_addr = a;
    #1;
    d = bus_rdata;
    bus_sel = 1'b0;
  endtask

  task automatic set_mtime(input logic [63:0] m);
    bus_write(3'd0, m[31:0]);
    bus_write(3'd1, m[63:32]);
  endtask

  task automatic read_mtime(output logic [63:0] m);
    logic [31:0] lo, hi;
    bus_read(3'd0, lo);
    bus_read(3'd1, hi);
    m = {hi, lo};
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    rst = 1'b1; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    ext_irq_i = 1'b0; irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (interrupt !== 4'd0) $display("FAIL reset_irq got=%0d want=0", interrupt);
    else passed++;
    total++;
    if (bus_rdata !== 32'd0) $display("FAIL idle_rdata got=%h want=0", bus_rdata);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'd0;
      bus_read(3'(i), rd);
      total++;
      if (rd !== exp) $display("FAIL reset_reg%0d got=%h want=%h", i, rd, exp);
      else passed++;
    end
    repeat (10) @(negedge clk);
    bus_read(3'd0, rd);
    total++;
    if (rd !== 32'd0 || interrupt !== 4'd0)
      $display("FAIL mtime_disabled got=%h irq=%0d want=0 irq=0", rd, interrupt);
    else passed++;
  endtask

  task automatic test_regs();
    logic [31:0] model [8];
    logic [31:0] rd, d;
    int unsigned a;
    model = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int n = 0; n < 24; n++) begin
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (a == 4) d = d & ~32'h3;
        bus_write(3'(a), d);
        if (a < 4) model[a] = d;
        else if (a == 4) model[4] = d & 32'h0000_FF00;
      end else begin
        bus_read(3'(a), rd);
        total++;
        if (rd !== model[a]) $display("FAIL reg_rw addr=%0d got=%h want=%h", a, rd, model[a]);
        else passed++;
        @(negedge clk);
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), rd);
      total++;
      if (rd !== model[i]) $display("FAIL reg_final addr=%0d got=%h want=%h", i, rd, model[i]);
      else passed++;
    end
  endtask

  task automatic test_prescale();
    logic [63:0] m0, got, exp;
    int unsigned p, k;
    for (int it = 0; it < 6; it++) begin
      bus_write(3'd4, 32'd0);
      m0 = {$urandom, $urandom};
      if (it % 2 == 1) m0[31:0] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      set_mtime(m0);
      p = $urandom_range(0, 7);
      k = $urandom_range(0, 60);
      bus_write(3'd4, (32'(p) << 8) | 32'd1);
      repeat (k) @(negedge clk);
      read_mtime(got);
      exp = m0 + 64'(k / (p + 1));
      total++;
      if (got !== exp) $display("FAIL prescale p=%0d k=%0d got=%h want=%h", p, k, got, exp);
      else passed++;
    end
  endtask

  task automatic test_timer_irq();
    logic [63:0] m;
    logic [31:0] rd;
    logic ok;
    bus_write(3'd4, 32'd0);
    set_mtime(64'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd10);
    bus_write(3'd4, 32'h301);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (c == 40) begin
        read_mtime(m);
        total++;
        if (m !== 64'd10) $display("FAIL tmr_mtime40 got=%h want=a", m);
        else passed++;
      end
      if (c == 41) begin
        total++;
        if (interrupt !== 4'd0) $display("FAIL tmr_early got=%0d want=0", interrupt);
        else passed++;
      end
      if (c == 42) begin
        total++;
        if (interrupt !== 4'd1) $display("FAIL tmr_latency got=%0d want=1", interrupt);
        else passed++;
      end
    end
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (interrupt !== 4'd1) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL tmr_hold got=dropped want=held");
    else passed++;
    pulse_ack();
    bus_read(3'd5, rd);
    total++;
    if (interrupt !== 4'd0 || rd !== 32'd0)
      $display("FAIL tmr_ack irq=%0d status=%h want irq=0 status=0", interrupt, rd);
    else passed++;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (interrupt !== 4'd0) ok = 1'b0;
    end
    total++;
    if (!ok) $display("FAIL tmr_refire got=refired want=quiet");
    else passed++;
  endtask

  task automatic test_carry();
    logic [63:0] m;
    logic [31:0] rd;
    bus_write(3'd4, 32'd0);
    set_mtime(64'h0000_0000_FFFF_FFFF);
    bus_write(3'd4, 32'd1);
    @(negedge clk);
    read_mtime(m);
    total++;
    if (m !== 64'h0000_0001_0000_0000) $display("FAIL carry got=%h want=100000000", m);
    else passed++;
    bus_write(3'd4, 32'd0);
    set_mtime(64'hFFFF_FFFF_FFFF_FFFF);
    bus_write(3'd4, 32'd1);
    @(negedge clk);
    read_mtime(m);
    total++;
    if (m !== 64'd0) $display("FAIL wrap got=%h want=0", m);
    else passed++;
    bus_write(3'd0, 32'h1234_0000);
    bus_read(3'd0, rd);
    total++;
    if (rd !== 32'h1234_0000) $display("FAIL wr_suppress got=%h want=12340000", rd);
    else passed++;
    repeat (5) @(negedge clk);
    bus_read(3'd0, rd);
    total++;
    if (rd !== 32'h1234_0005) $display("FAIL wr_resume got=%h want=12340005", rd);
    else passed++;
  endtask

  task automatic test_ext();
    logic [31:0] rd;
    bus_write(3'd4, 32'd0);
    ext_irq_i = 1'b1;
    repeat (3) @(negedge clk);
    ext_irq_i = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(3'd5, rd);
    total++;
    if (rd !== 32'd0 || interrupt !== 4'd0)
      $display("FAIL ext_disabled status=%h irq=%0d want 0/0", rd, interrupt);
    else passed++;

    bus_write(3'd4, 32'd2);
    repeat (2) @(negedge clk);
    ext_irq_i = 1'b1;
    for (int c = 1; c <= int'(SYNC) + 2; c++) begin
      @(negedge clk);
      if (c == 3) ext_irq_i = 1'b0;
      if (c == int'(SYNC) + 1) begin
        total++;
        if (interrupt !== 4'd0) $display("FAIL ext_early got=%0d want=0", interrupt);
        else passed++;
      end
      if (c == int'(SYNC) + 2) begin
        total++;
        if (interrupt !== 4'd2) $display("FAIL ext_latency got=%0d want=2", interrupt);
        else passed++;
      end
    end
    ext_irq_i = 1'b0;
    bus_read(3'd5, rd);
    total++;
    if (rd !== 32'd2) $display("FAIL ext_status got=%h want=2", rd);
    else passed++;
    pulse_ack();
    bus_read(3'd5, rd);
    total++;
    if (interrupt !== 4'd0 || rd !== 32'd0)
      $display("FAIL ext_ack irq=%0d status=%h want 0/0", interrupt, rd);
    else passed++;
  endtask

  task automatic test_both();
    logic [31:0] rd;
    bus_write(3'd4, 32'd0);
    set_mtime(64'd100);
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd50);
    repeat (3) @(negedge clk);
    // External edge and timer crossing both land on the same pend edge.
    ext_irq_i = 1'b1;
    @(negedge clk);
    bus_write(3'd4, 32'd3);
    @(negedge clk);
    bus_read(3'd5, rd);
    total++;
    if (rd !== 32'd3 || interrupt !== 4'd0)
      $display("FAIL both_pend status=%h irq=%0d want 3/0", rd, interrupt);
    else passed++;
    @(negedge clk);
    total++;
    if (interrupt !== 4'd2) $display("FAIL both_prio got=%0d want=2", interrupt);
    else passed++;
    pulse_ack();
    total++;
    if (interrupt !== 4'd0) $display("FAIL both_gap got=%0d want=0", interrupt);
    else passed++;
    @(negedge clk);
    total++;
    if (interrupt !== 4'd1) $display("FAIL both_second got=%0d want=1", interrupt);
    else passed++;
    pulse_ack();
    ext_irq_i = 1'b0;
    total++;
    if (interrupt !== 4'd0) $display("FAIL both_done got=%0d want=0", interrupt);
    else passed++;
  endtask

  task automatic test_withdraw();
    logic [31:0] rd;
    logic got;
    bus_write(3'd4, 32'd0);
    set_mtime(64'd100);
    bus_write(3'd4, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (interrupt === 4'd1) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got) $display("FAIL withdraw_req got=%0d want=1", interrupt);
    else passed++;
    bus_write(3'd5, 32'd1);
    bus_read(3'd5, rd);
    total++;
    if (interrupt !== 4'd0 || rd !== 32'd0)
      $display("FAIL withdraw irq=%0d status=%h want 0/0", interrupt, rd);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (interrupt !== 4'd0) $display("FAIL withdraw_stay got=%0d want=0", interrupt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic got;
    bus_write(3'd4, 32'd2);
    ext_irq_i = 1'b1;
    repeat (3) @(negedge clk);
    ext_irq_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (interrupt === 4'd2) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got) $display("FAIL b2b_req got=%0d want=2", interrupt);
    else passed++;
    repeat (4) @(negedge clk);
    // New edge reaches the pend bit on the same edge as the ack.
    ext_irq_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pulse_ack();
    bus_read(3'd5, rd);
    total++;
    if (rd !== 32'd2 || interrupt !== 4'd0)
      $display("FAIL b2b_set_wins status=%h irq=%0d want 2/0", rd, interrupt);
    else passed++;
    @(negedge clk);
    total++;
    if (interrupt !== 4'd2) $display("FAIL b2b_rerequest got=%0d want=2", interrupt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (interrupt !== 4'd0) $display("FAIL rst_async got=%0d want=0", interrupt);
    else passed++;
    ext_irq_i = 1'b0;
    bus_read(3'd4, rd);
    total++;
    if (rd !== 32'd0) $display("FAIL rst_ctrl got=%h want=0", rd);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    bus_read(3'd3, rd);
    total++;
    if (rd !== 32'hFFFF_FFFF || interrupt !== 4'd0)
      $display("FAIL rst_after cmp_hi=%h irq=%0d want ffffffff/0", rd, interrupt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_prescale();
    test_timer_irq();
    test_carry();
    test_ext();
    test_both();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
